// File: rtl/knn_seq_ctrl_pkg.sv
// knn_seq_ctrl_pkg: shared definitions for the KNN sequencer.
//   - Default run geometry (points per run, neighbour slots).
//   - Sequencer state encoding (4 bits).
package knn_seq_ctrl_pkg;

    localparam int unsigned KNN_N_POINTS_DEFAULT = 16;
    localparam int unsigned KNN_K_DEFAULT        = 4;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StClear  = 4'd1,
        StFetch  = 4'd2,
        StLaunch = 4'd3,
        StWait   = 4'd4,
        StCmp    = 4'd5,
        StIns    = 4'd6,
        StNext   = 4'd7,
        StDone   = 4'd8
    } knn_state_e;

endpackage

// File: rtl/knn_seq_ctrl.sv
// knn_seq_ctrl: top-level sequencer of the KNN accelerator datapath.
// On start it clears the neighbour list, then for every stored point fetches it, launches the
// distance unit, waits for the result, scans the K neighbour slots in order and either inserts
// the point or discards it. All outputs are registered Moore outputs.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         run request, only honoured while idle
//   busy_o, done_o  run in progress / one-cycle end-of-run pulse
//   mem_rd_en_o, mem_addr_o     data-memory read of the current point
//   dist_start_o, dist_valid_i  distance unit launch / result ready
//   cmp_idx_o, cmp_less_i       slot being compared / new distance strictly less than it
//   nb_clr_o, nb_ins_o, nb_ins_idx_o, nb_fill_o  neighbour-list control and fill level
//   perf_cycles_o   busy-cycle counter (only with KNN_PERF_CNT_EN defined)
//
// Build option: define KNN_PERF_CNT_EN to add the saturating perf_cycles_o counter.
module knn_seq_ctrl
    import knn_seq_ctrl_pkg::*;
#(
    parameter int unsigned N_POINTS = KNN_N_POINTS_DEFAULT,
    parameter int unsigned K        = KNN_K_DEFAULT,
    parameter int unsigned IDX_W    = $clog2(N_POINTS),
    parameter int unsigned SLOT_W   = $clog2(K)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_en_o,
    output logic [IDX_W-1:0]  mem_addr_o,
    output logic              dist_start_o,
    input  logic              dist_valid_i,
    output logic [SLOT_W-1:0] cmp_idx_o,
    input  logic              cmp_less_i,
    output logic              nb_clr_o,
    output logic              nb_ins_o,
    output logic [SLOT_W-1:0] nb_ins_idx_o,
`ifdef KNN_PERF_CNT_EN
    output logic [31:0]       perf_cycles_o,
`endif
    output logic [SLOT_W:0]   nb_fill_o
);

    knn_state_e        state_q, state_d;
    logic [IDX_W-1:0]  pt_idx_q, pt_idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SLOT_W:0]   fill_q, fill_d;

    logic              busy_q, done_q, mem_rd_en_q, dist_start_q, nb_clr_q, nb_ins_q;
    logic [IDX_W-1:0]  mem_addr_q;
    logic [SLOT_W-1:0] nb_ins_idx_q;

    logic slot_empty, slot_last, pt_last, fill_full;

    assign slot_empty = ({1'b0, slot_q} >= fill_q);
    assign slot_last  = (slot_q == SLOT_W'(K - 1));
    assign pt_last    = (pt_idx_q == IDX_W'(N_POINTS - 1));
    assign fill_full  = (fill_q == (SLOT_W + 1)'(K));

    always_comb begin
        state_d  = state_q;
        pt_idx_d = pt_idx_q;
        slot_d   = slot_q;
        fill_d   = fill_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StClear;
            end
            StClear: begin
                pt_idx_d = '0;
                fill_d   = '0;
                state_d  = StFetch;
            end
            StFetch:  state_d = StLaunch;
            StLaunch: state_d = StWait;
            StWait: begin
                if (dist_valid_i) begin
                    slot_d  = '0;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                // An empty slot takes the point regardless of cmp_less_i; equal distances
                // never displace, so the earlier point keeps its slot.
                if (slot_empty || cmp_less_i) begin
                    state_d = StIns;
                end else if (slot_last) begin
                    state_d = StNext;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            StIns: begin
                if (!fill_full) fill_d = fill_q + 1'b1;
                state_d = StNext;
            end
            StNext: begin
                if (pt_last) begin
                    state_d = StDone;
                end else begin
                    pt_idx_d = pt_idx_q + 1'b1;
                    state_d  = StFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pt_idx_q     <= '0;
            slot_q       <= '0;
            fill_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            dist_start_q <= 1'b0;
            nb_clr_q     <= 1'b0;
            nb_ins_q     <= 1'b0;
            nb_ins_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            pt_idx_q     <= pt_idx_d;
            slot_q       <= slot_d;
            fill_q       <= fill_d;
            busy_q       <= (state_d != StIdle);
            done_q       <= (state_d == StDone);
            mem_rd_en_q  <= (state_d == StFetch);
            mem_addr_q   <= (state_d == StFetch) ? pt_idx_d : '0;
            dist_start_q <= (state_d == StLaunch);
            nb_clr_q     <= (state_d == StClear);
            nb_ins_q     <= (state_d == StIns);
            nb_ins_idx_q <= (state_d == StIns) ? slot_d : '0;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign mem_rd_en_o  = mem_rd_en_q;
    assign mem_addr_o   = mem_addr_q;
    assign dist_start_o = dist_start_q;
    assign cmp_idx_o    = slot_q;
    assign nb_clr_o     = nb_clr_q;
    assign nb_ins_o     = nb_ins_q;
    assign nb_ins_idx_o = nb_ins_idx_q;
    assign nb_fill_o    = fill_q;

`ifdef KNN_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == StIdle && start_i) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule
